// File: rtl/unified_mem_requester_pkg.sv
// Shared types for the unified memory requester:
// func3 codes, response-tag FSM states, legality rule.
package unified_mem_requester_pkg;

    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;
    localparam logic [2:0] FUNC3_SB  = 3'b000;
    localparam logic [2:0] FUNC3_SH  = 3'b001;
    localparam logic [2:0] FUNC3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_e;

    // Width is legal for the direction and the address is naturally aligned.
    function automatic logic is_legal_access(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (f3)
                FUNC3_SB: ok = 1'b1;
                FUNC3_SH: ok = ~lo[0];
                FUNC3_SW: ok = (lo == 2'b00);
                default:  ok = 1'b0;
            endcase
        end else begin
            case (f3)
                FUNC3_LB, FUNC3_LBU: ok = 1'b1;
                FUNC3_LH, FUNC3_LHU: ok = ~lo[0];
                FUNC3_LW:            ok = (lo == 2'b00);
                default:             ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/unified_mem_requester_if.sv
// Bundle of pipeline-side handshakes and memory-side bus
// seen by the unified memory requester.
interface unified_mem_requester_if #(parameter int AW = 8);

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic          if_valid;
    logic [31:0]   if_instr;

    logic          d_req;
    logic          d_we;
    logic [2:0]    d_func3;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_ready;
    logic          d_valid;
    logic [31:0]   d_rdata;
    logic          d_err;

    logic          mem_fetch;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_func3;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // Requester view: drives responses and the memory strobes.
    modport master (
        input  if_req, if_addr,
        input  d_req, d_we, d_func3, d_addr, d_wdata,
        input  mem_rdata,
        output if_ready, if_valid, if_instr,
        output d_ready, d_valid, d_rdata, d_err,
        output mem_fetch, mem_addr, mem_func3,
        output mem_read, mem_write, mem_wdata
    );

    // Pipeline and memory view.
    modport slave (
        output if_req, if_addr,
        output d_req, d_we, d_func3, d_addr, d_wdata,
        output mem_rdata,
        input  if_ready, if_valid, if_instr,
        input  d_ready, d_valid, d_rdata, d_err,
        input  mem_fetch, mem_addr, mem_func3,
        input  mem_read, mem_write, mem_wdata
    );

endinterface

// File: rtl/unified_mem_requester_checker.sv
// Combinational width/alignment legality check
// for data-side requests.
module unified_mem_requester_checker
    import unified_mem_requester_pkg::*;
(
    input  logic       we_i,
    input  logic [2:0] func3_i,
    input  logic [1:0] addr_lo_i,
    output logic       legal_o
);

    // Legal when func3 fits the direction and the address is aligned.
    always_comb legal_o = is_legal_access(we_i, func3_i, addr_lo_i);

endmodule

// File: rtl/unified_mem_requester.sv
// Arbitrates fetch vs load/store onto the single-ported memory
// and returns registered, one-cycle response pulses.
module unified_mem_requester
    import unified_mem_requester_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 8
) (
    input logic clk,
    input logic rst,
    unified_mem_requester_if.master bus
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    state_e        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [31:0]   if_instr_q, if_instr_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          d_err_q, d_err_d;
    logic          if_acc, d_acc, legal, starved;
    logic [AW-1:0] addr_sel;

    unified_mem_requester_checker u_chk (
        .we_i      (bus.d_we),
        .func3_i   (bus.d_func3),
        .addr_lo_i (bus.d_addr[1:0]),
        .legal_o   (legal)
    );

    assign starved = (starve_q == SMAX);

    // Grant: data first unless fetch has waited long enough; none in reset.
    always_comb begin
        if_acc = 1'b0;
        d_acc  = 1'b0;
        if (!rst) begin
            if (bus.if_req && (!bus.d_req || starved)) begin
                if_acc = 1'b1;
            end else if (bus.d_req) begin
                d_acc = 1'b1;
            end
        end
    end

    // Count consecutive denied fetch cycles, saturating.
    always_comb begin
        starve_d = '0;
        if (bus.if_req && !if_acc) begin
            starve_d = starved ? starve_q : starve_q + 1'b1;
        end
    end

    // Response tag: which valid fires in the next cycle.
    always_comb begin
        state_d = IDLE;
        if (if_acc) begin
            state_d = RESP_I;
        end else if (d_acc) begin
            state_d = RESP_D;
        end
    end

    // Response payload captured from memory in the accept cycle.
    always_comb begin
        if_instr_d = if_instr_q;
        d_rdata_d  = d_rdata_q;
        d_err_d    = 1'b0;
        if (if_acc) begin
            if_instr_d = bus.mem_rdata;
        end
        if (d_acc) begin
            d_err_d   = ~legal;
            d_rdata_d = (legal && !bus.d_we) ? bus.mem_rdata : 32'h0;
        end
    end

    // State, counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            if_instr_q <= 32'h0;
            d_rdata_q  <= 32'h0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            if_instr_q <= if_instr_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
        end
    end

    // Handshake, response and memory-bus outputs.
    always_comb begin
        addr_sel      = if_acc ? bus.if_addr : bus.d_addr;
        bus.if_ready  = if_acc;
        bus.d_ready   = d_acc;
        bus.if_valid  = (state_q == RESP_I);
        bus.d_valid   = (state_q == RESP_D);
        bus.if_instr  = if_instr_q;
        bus.d_rdata   = d_rdata_q;
        bus.d_err     = d_err_q;
        bus.mem_fetch = if_acc;
        bus.mem_addr  = addr_sel;
        bus.mem_func3 = if_acc ? 3'b000 : bus.d_func3;
        bus.mem_read  = d_acc && legal && !bus.d_we;
        bus.mem_write = d_acc && legal && bus.d_we;
        bus.mem_wdata = bus.d_wdata;
    end

endmodule
